// File: rtl/pong_video_pkg.sv
// pong_video_pkg: shared timing constants and types for the pong video path.
//   - Default 640x480@60 and 800x600@60 raster timings (pixels / lines).
//   - sync_pol_e: encoding of the sync polarity parameter.
//   - clog2_min1: counter width helper that never returns 0.
package pong_video_pkg;

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    // 640x480@60, 25.175 MHz nominal pixel clock
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // 800x600@60, 40 MHz nominal pixel clock
    localparam int VGA800_H_ACTIVE = 800;
    localparam int VGA800_H_FP     = 40;
    localparam int VGA800_H_SYNC   = 128;
    localparam int VGA800_H_BP     = 88;
    localparam int VGA800_V_ACTIVE = 600;
    localparam int VGA800_V_FP     = 1;
    localparam int VGA800_V_SYNC   = 4;
    localparam int VGA800_V_BP     = 23;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pong_video_counter.sv
// pong_video_counter: modulo-N up counter used for the raster x and y counts.
//   clk    : system clock
//   reset  : synchronous active-high clear
//   tick   : advance enable
//   count  : current value, 0..N-1
//   wrap   : tick while count == N-1 (count returns to 0 on this edge)
module pong_video_counter
    import pong_video_pkg::*;
#(
    parameter int N = 800,
    parameter int W = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign wrap = tick && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/pong_video_timing.sv
// pong_video_timing: parametrised VGA raster engine for the pong core.
//   clk, reset          : system clock, synchronous active-high reset
//   enable              : raster run; low parks the raster in the reset state
//   pix_x, pix_y        : current raster coordinate handed to the renderer
//   pix_tick            : one-clk pixel advance strobe
//   pix_active          : coordinate lies inside the visible area
//   line_start          : pix_tick at pix_x == 0
//   frame_start         : pix_tick at pix_x == 0, pix_y == 0
//   red/green/blue_in   : renderer colour for the coordinate issued PIX_LAT ticks ago
//   red/green/blue      : registered colour to the pads (blanked outside active)
//   hsync, vsync        : registered syncs, polarity set by SYNC_POL
//   io_oeb              : pad output enables, active-low, all off during reset
// Optional build macro VGA_TESTPATTERN_EN adds input test_mode, which replaces
// the renderer colour with 8 vertical colour bars.
module pong_video_timing
    import pong_video_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter int COLOR_W  = 4,
    parameter int CLK_DIV  = 2,
    parameter int PIX_LAT  = 1,
    parameter int SYNC_POL = 0,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = clog2_min1(H_TOTAL),
    localparam int YW      = clog2_min1(V_TOTAL)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
`ifdef VGA_TESTPATTERN_EN
    input  logic               test_mode,
`endif
    output logic [XW-1:0]      pix_x,
    output logic [YW-1:0]      pix_y,
    output logic               pix_tick,
    output logic               pix_active,
    output logic               line_start,
    output logic               frame_start,
    input  logic [COLOR_W-1:0] red_in,
    input  logic [COLOR_W-1:0] green_in,
    input  logic [COLOR_W-1:0] blue_in,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               hsync,
    output logic               vsync,
    output logic [15:0]        io_oeb
);

    localparam int DIV_W = clog2_min1(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic SYNC_IDLE = (SYNC_POL == int'(SYNC_ACTIVE_HIGH)) ? 1'b0 : 1'b1;

    // Comparisons use one extra bit so a boundary equal to H_TOTAL/V_TOTAL
    // cannot alias to 0 when the total is a power of two.
    localparam int XW1 = XW + 1;
    localparam int YW1 = YW + 1;
    localparam logic [XW1-1:0] H_ACT_END = XW1'(H_ACTIVE);
    localparam logic [XW1-1:0] HS_ON     = XW1'(H_ACTIVE + H_FP);
    localparam logic [XW1-1:0] HS_OFF    = XW1'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW1-1:0] V_ACT_END = YW1'(V_ACTIVE);
    localparam logic [YW1-1:0] VS_ON     = YW1'(V_ACTIVE + V_FP);
    localparam logic [YW1-1:0] VS_OFF    = YW1'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_TESTPATTERN_EN
    localparam int TW = 3 + XW;   // {hs, vs, active, x}
`else
    localparam int TW = 3;        // {hs, vs, active}
`endif

    // Reset and enable-low park the raster identically.
    logic clr;
    assign clr = reset || !enable;

    // ---------------------------------------------------------------------
    // Pixel divider. run delays counting by one clk after release so the
    // first tick lands exactly CLK_DIV clks after enable/reset release.
    // ---------------------------------------------------------------------
    logic             run;
    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            run     <= 1'b0;
            div_cnt <= '0;
        end else begin
            run <= 1'b1;
            if (run) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    assign pix_tick = run && (div_cnt == DIV_LAST);

    // ---------------------------------------------------------------------
    // Raster counters
    // ---------------------------------------------------------------------
    logic h_wrap;
    logic v_wrap_unused;

    pong_video_counter #(.N(H_TOTAL), .W(XW)) u_h_cnt (
        .clk   (clk),
        .reset (clr),
        .tick  (pix_tick),
        .count (pix_x),
        .wrap  (h_wrap)
    );

    pong_video_counter #(.N(V_TOTAL), .W(YW)) u_v_cnt (
        .clk   (clk),
        .reset (clr),
        .tick  (h_wrap),
        .count (pix_y),
        .wrap  (v_wrap_unused)
    );

    assign line_start  = pix_tick && (pix_x == '0);
    assign frame_start = line_start && (pix_y == '0);

    // ---------------------------------------------------------------------
    // Raw timing decode
    // ---------------------------------------------------------------------
    logic [XW1-1:0] x_ext;
    logic [YW1-1:0] y_ext;
    logic           hs_raw, vs_raw, act_raw;

    assign x_ext      = {1'b0, pix_x};
    assign y_ext      = {1'b0, pix_y};
    assign act_raw    = (x_ext < H_ACT_END) && (y_ext < V_ACT_END);
    assign hs_raw     = (x_ext >= HS_ON) && (x_ext < HS_OFF);
    assign vs_raw     = (y_ext >= VS_ON) && (y_ext < VS_OFF);
    assign pix_active = act_raw;

    // ---------------------------------------------------------------------
    // Alignment pipeline: holds timing taps for PIX_LAT ticks so they meet
    // the renderer colour that comes back for the same coordinate.
    // ---------------------------------------------------------------------
    logic [TW-1:0] tap_raw, tap_d;

`ifdef VGA_TESTPATTERN_EN
    assign tap_raw = {hs_raw, vs_raw, act_raw, pix_x};
`else
    assign tap_raw = {hs_raw, vs_raw, act_raw};
`endif

    generate
        if (PIX_LAT == 0) begin : g_no_lat
            assign tap_d = tap_raw;
        end else begin : g_lat
            logic [PIX_LAT-1:0][TW-1:0] tap_pipe;

            always_ff @(posedge clk) begin
                if (clr) begin
                    tap_pipe <= '0;
                end else if (pix_tick) begin
                    tap_pipe[0] <= tap_raw;
                    for (int i = 1; i < PIX_LAT; i++) tap_pipe[i] <= tap_pipe[i-1];
                end
            end

            assign tap_d = tap_pipe[PIX_LAT-1];
        end
    endgenerate

    logic hs_d, vs_d, act_d;
    assign hs_d  = tap_d[TW-1];
    assign vs_d  = tap_d[TW-2];
    assign act_d = tap_d[TW-3];

    // ---------------------------------------------------------------------
    // Colour source
    // ---------------------------------------------------------------------
    logic [COLOR_W-1:0] r_nxt, g_nxt, b_nxt;

`ifdef VGA_TESTPATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    logic [XW-1:0] x_d, bar_idx;
    logic [2:0]    bar;

    assign x_d     = tap_d[XW-1:0];
    assign bar_idx = x_d / XW'(BAR_W);
    // Clamp so a non-multiple-of-8 width keeps its last sliver in bar 7.
    assign bar     = (bar_idx > XW'(7)) ? 3'd7 : bar_idx[2:0];
`endif

    always_comb begin
        r_nxt = red_in;
        g_nxt = green_in;
        b_nxt = blue_in;
`ifdef VGA_TESTPATTERN_EN
        if (test_mode) begin
            r_nxt = {COLOR_W{bar[2]}};
            g_nxt = {COLOR_W{bar[1]}};
            b_nxt = {COLOR_W{bar[0]}};
        end
`endif
    end

    // ---------------------------------------------------------------------
    // Pad registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
            hsync <= SYNC_IDLE;
            vsync <= SYNC_IDLE;
        end else if (pix_tick) begin
            red   <= act_d ? r_nxt : '0;
            green <= act_d ? g_nxt : '0;
            blue  <= act_d ? b_nxt : '0;
            hsync <= hs_d ^ SYNC_IDLE;
            vsync <= vs_d ^ SYNC_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        io_oeb <= reset ? 16'hFFFF : 16'h0000;
    end

endmodule

// File: tb/tb_pong_video_timing.sv
module tb_pong_video_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: default horizontal timing, CLK_DIV=2, short 8-line frame
    logic       rst_a = 1'b1, en_a = 1'b0;
    logic [9:0] pix_x_a;
    logic [2:0] pix_y_a;
    logic       pix_tick_a, pix_active_a, line_start_a, frame_start_a;
    logic [3:0] red_in_a, green_in_a, blue_in_a, red_a, green_a, blue_a;
    logic       hsync_a, vsync_a;
    logic [15:0] io_oeb_a;
    int         color_mode = 0;

    // renderer with one tick of latency: colour for x arrives while pix_x = x+1
    assign red_in_a   = (color_mode == 1) ? 4'(pix_x_a[3:0] - 4'd1) :
                        (color_mode == 2) ? 4'hF : 4'h0;
    assign green_in_a = (color_mode == 2) ? 4'hF : 4'h0;
    assign blue_in_a  = (color_mode == 2) ? 4'hF : 4'h0;

`ifdef VGA_TESTPATTERN_EN
    logic tm_a = 1'b0;
    logic tm_b = 1'b0;
`endif

    pong_video_timing #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a),
`ifdef VGA_TESTPATTERN_EN
        .test_mode(tm_a),
`endif
        .pix_x(pix_x_a), .pix_y(pix_y_a), .pix_tick(pix_tick_a),
        .pix_active(pix_active_a), .line_start(line_start_a), .frame_start(frame_start_a),
        .red_in(red_in_a), .green_in(green_in_a), .blue_in(blue_in_a),
        .red(red_a), .green(green_a), .blue(blue_a),
        .hsync(hsync_a), .vsync(vsync_a), .io_oeb(io_oeb_a)
    );

    // DUT B: tiny raster, CLK_DIV=1, active-high syncs
    logic       rst_b = 1'b1, en_b = 1'b0;
    logic [2:0] pix_x_b, pix_y_b;
    logic       pix_tick_b, pix_active_b, line_start_b, frame_start_b;
    logic [3:0] red_b, green_b, blue_b;
    logic       hsync_b, vsync_b;
    logic [15:0] io_oeb_b;
    logic [3:0] col_b = 4'hF;

    pong_video_timing #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .PIX_LAT(1), .SYNC_POL(1)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b),
`ifdef VGA_TESTPATTERN_EN
        .test_mode(tm_b),
`endif
        .pix_x(pix_x_b), .pix_y(pix_y_b), .pix_tick(pix_tick_b),
        .pix_active(pix_active_b), .line_start(line_start_b), .frame_start(frame_start_b),
        .red_in(col_b), .green_in(col_b), .blue_in(col_b),
        .red(red_b), .green(green_b), .blue(blue_b),
        .hsync(hsync_b), .vsync(vsync_b), .io_oeb(io_oeb_b)
    );

    // Bounded waits for a tick at a given coordinate (y < 0: any line).
    task automatic wait_a(input int x, input int y, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (pix_tick_a && int'(pix_x_a) == x && (y < 0 || int'(pix_y_a) == y)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_a timeout: no tick at x=%0d y=%0d within budget", x, y);
        end
    endtask

    task automatic wait_b(input int x, input int y, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (pix_tick_b && int'(pix_x_b) == x && (y < 0 || int'(pix_y_b) == y)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_b timeout: no tick at x=%0d y=%0d within budget", x, y);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pix_x_a, pix_y_a} !== 13'd0) begin errors++;
            $display("FAIL reset_xy got x=%0d y=%0d want 0 0", pix_x_a, pix_y_a); end
        checks++;
        if ({pix_tick_a, line_start_a, frame_start_a} !== 3'b000) begin errors++;
            $display("FAIL reset_strobes got %b want 000", {pix_tick_a, line_start_a, frame_start_a}); end
        checks++;
        if ({red_a, green_a, blue_a, hsync_a, vsync_a} !== 14'b00_0000_0000_0011) begin errors++;
            $display("FAIL reset_pads got rgb=%h%h%h hs=%b vs=%b want 000 1 1", red_a, green_a, blue_a, hsync_a, vsync_a); end
        checks++;
        if (io_oeb_a !== 16'hFFFF) begin errors++;
            $display("FAIL reset_oeb got %h want FFFF", io_oeb_a); end
        checks++;
        if ({hsync_b, vsync_b, pix_tick_b, io_oeb_b} !== {3'b000, 16'hFFFF}) begin errors++;
            $display("FAIL reset_b got hs=%b vs=%b tick=%b oeb=%h want 0 0 0 FFFF", hsync_b, vsync_b, pix_tick_b, io_oeb_b); end
    endtask

    task automatic test_start();
        rst_a = 1'b0; en_a = 1'b1;
        @(negedge clk);
        checks++;
        if (pix_tick_a !== 1'b0 || io_oeb_a !== 16'h0000) begin errors++;
            $display("FAIL start_clk1 got tick=%b oeb=%h want 0 0000", pix_tick_a, io_oeb_a); end
        @(negedge clk);
        checks++;
        if ({pix_tick_a, frame_start_a, line_start_a} !== 3'b111 || pix_x_a !== 10'd0 || pix_y_a !== 3'd0) begin errors++;
            $display("FAIL start_first_tick got tick/fs/ls=%b x=%0d y=%0d want 111 0 0",
                     {pix_tick_a, frame_start_a, line_start_a}, pix_x_a, pix_y_a); end
        @(negedge clk);
        checks++;
        if ({pix_tick_a, frame_start_a, line_start_a} !== 3'b000 || pix_x_a !== 10'd1) begin errors++;
            $display("FAIL start_pulse_width got tick/fs/ls=%b x=%0d want 000 1",
                     {pix_tick_a, frame_start_a, line_start_a}, pix_x_a); end
    endtask

    task automatic test_frame_timing();
        bit ok;
        int clks, ticks, line_clks, line_ticks;
        wait_a(0, 0, ok);
        clks = 0; ticks = 1; line_clks = -1; line_ticks = -1;
        for (int n = 0; n < 14000; n++) begin
            @(negedge clk);
            clks++;
            if (frame_start_a) break;
            if (line_start_a && line_clks < 0) begin line_clks = clks; line_ticks = ticks; end
            if (pix_tick_a) ticks++;
        end
        checks++;
        if (clks != 12800) begin errors++; $display("FAIL frame_clks got %0d want 12800", clks); end
        checks++;
        if (line_clks != 1600) begin errors++; $display("FAIL line_clks got %0d want 1600", line_clks); end
        checks++;
        if (line_ticks != 800) begin errors++; $display("FAIL line_ticks got %0d want 800", line_ticks); end
    endtask

    task automatic test_hsync();
        bit ok;
        int lows, first, last, n;
        wait_a(0, -1, ok);
        lows = 0; first = -1; last = -1; n = 0;
        for (int c = 0; c < 2000 && n < 800; c++) begin
            if (pix_tick_a) begin
                if (hsync_a == 1'b0) begin
                    lows++;
                    if (first < 0) first = int'(pix_x_a);
                    last = int'(pix_x_a);
                end
                n++;
            end
            if (n < 800) @(negedge clk);
        end
        checks++;
        if (lows != 96) begin errors++; $display("FAIL hsync_width got %0d want 96", lows); end
        checks++;
        if (first != 658) begin errors++; $display("FAIL hsync_first got x=%0d want 658", first); end
        checks++;
        if (last != 753) begin errors++; $display("FAIL hsync_last got x=%0d want 753", last); end
    endtask

    task automatic test_vsync();
        bit ok;
        wait_a(1, 5, ok);
        checks++;
        if (vsync_a !== 1'b1) begin errors++; $display("FAIL vsync_y5x1 got %b want 1", vsync_a); end
        wait_a(2, 5, ok);
        checks++;
        if (vsync_a !== 1'b0) begin errors++; $display("FAIL vsync_y5x2 got %b want 0", vsync_a); end
        wait_a(1, 7, ok);
        checks++;
        if (vsync_a !== 1'b0) begin errors++; $display("FAIL vsync_y7x1 got %b want 0", vsync_a); end
        wait_a(2, 7, ok);
        checks++;
        if (vsync_a !== 1'b1) begin errors++; $display("FAIL vsync_y7x2 got %b want 1", vsync_a); end
    endtask

    task automatic test_colour();
        bit ok;
        color_mode = 1;
        wait_a(7, 1, ok);
        checks++;
        if (red_a !== 4'd5) begin errors++; $display("FAIL colour_x5 got %h want 5", red_a); end
        wait_a(20, 1, ok);
        checks++;
        if (red_a !== 4'd2) begin errors++; $display("FAIL colour_x18 got %h want 2", red_a); end
        wait_a(641, 1, ok);
        checks++;
        if (red_a !== 4'hF || pix_active_a !== 1'b0) begin errors++;
            $display("FAIL colour_x639 got red=%h active=%b want F 0", red_a, pix_active_a); end
        color_mode = 2;
        wait_a(643, 1, ok);
        checks++;
        if ({red_a, green_a, blue_a} !== 12'h000) begin errors++;
            $display("FAIL colour_blank got %h%h%h want 000", red_a, green_a, blue_a); end
        wait_a(3, 2, ok);
        checks++;
        if ({red_a, green_a, blue_a} !== 12'hFFF || pix_active_a !== 1'b1) begin errors++;
            $display("FAIL colour_white got %h%h%h active=%b want FFF 1", red_a, green_a, blue_a, pix_active_a); end
        color_mode = 0;
    endtask

    task automatic test_park_and_reset();
        bit ok;
        int n;
        wait_a(300, -1, ok);
        en_a = 1'b0;
        @(negedge clk);
        checks++;
        if (pix_x_a !== 10'd0 || pix_tick_a !== 1'b0 || io_oeb_a !== 16'h0000 || hsync_a !== 1'b1) begin errors++;
            $display("FAIL park got x=%0d tick=%b oeb=%h hs=%b want 0 0 0000 1", pix_x_a, pix_tick_a, io_oeb_a, hsync_a); end
        en_a = 1'b1;
        wait_a(300, -1, ok);
        rst_a = 1'b1;
        @(negedge clk);
        checks++;
        if (pix_x_a !== 10'd0 || pix_y_a !== 3'd0 || pix_tick_a !== 1'b0 ||
            {red_a, green_a, blue_a} !== 12'h000 || {hsync_a, vsync_a} !== 2'b11 || io_oeb_a !== 16'hFFFF) begin errors++;
            $display("FAIL midline_reset got x=%0d y=%0d tick=%b rgb=%h%h%h hs/vs=%b%b oeb=%h want 0 0 0 000 11 FFFF",
                     pix_x_a, pix_y_a, pix_tick_a, red_a, green_a, blue_a, hsync_a, vsync_a, io_oeb_a); end
        rst_a = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n++;
            if (pix_tick_a) break;
        end
        checks++;
        if (n != 2 || frame_start_a !== 1'b1 || pix_x_a !== 10'd0) begin errors++;
            $display("FAIL reset_release got clks=%0d fs=%b x=%0d want 2 1 0", n, frame_start_a, pix_x_a); end
    endtask

    task automatic test_small();
        bit ok;
        int clks, line_clks;
        rst_b = 1'b0; en_b = 1'b1;
        @(negedge clk);
        checks++;
        if (pix_tick_b !== 1'b1 || frame_start_b !== 1'b1 || pix_x_b !== 3'd0) begin errors++;
            $display("FAIL small_first got tick=%b fs=%b x=%0d want 1 1 0", pix_tick_b, frame_start_b, pix_x_b); end
        clks = 0; line_clks = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            clks++;
            if (frame_start_b) break;
            if (line_start_b && line_clks < 0) line_clks = clks;
        end
        checks++;
        if (line_clks != 7) begin errors++; $display("FAIL small_line got %0d want 7", line_clks); end
        checks++;
        if (clks != 35) begin errors++; $display("FAIL small_frame got %0d want 35", clks); end
        wait_b(0, -1, ok);
        checks++;
        if (hsync_b !== 1'b1) begin errors++; $display("FAIL small_hs_on got %b want 1", hsync_b); end
        wait_b(1, -1, ok);
        checks++;
        if (hsync_b !== 1'b0) begin errors++; $display("FAIL small_hs_off got %b want 0", hsync_b); end
        wait_b(2, 0, ok);
        checks++;
        if (red_b !== 4'hF) begin errors++; $display("FAIL small_red_active got %h want F", red_b); end
        wait_b(6, 0, ok);
        checks++;
        if (red_b !== 4'h0 || hsync_b !== 1'b0) begin errors++;
            $display("FAIL small_blank got red=%h hs=%b want 0 0", red_b, hsync_b); end
        wait_b(1, 3, ok);
        checks++;
        if (vsync_b !== 1'b0) begin errors++; $display("FAIL small_vs_before got %b want 0", vsync_b); end
        wait_b(2, 3, ok);
        checks++;
        if (vsync_b !== 1'b1) begin errors++; $display("FAIL small_vs_on got %b want 1", vsync_b); end
    endtask

`ifdef VGA_TESTPATTERN_EN
    task automatic test_pattern();
        bit ok;
        color_mode = 1;
        tm_a = 1'b1;
        wait_a(2, 1, ok);
        checks++;
        if ({red_a, green_a, blue_a} !== 12'h000) begin errors++;
            $display("FAIL bar0 got %h%h%h want 000", red_a, green_a, blue_a); end
        wait_a(82, 1, ok);
        checks++;
        if ({red_a, green_a, blue_a} !== 12'h00F) begin errors++;
            $display("FAIL bar1 got %h%h%h want 00F", red_a, green_a, blue_a); end
        wait_a(562, 1, ok);
        checks++;
        if ({red_a, green_a, blue_a} !== 12'hFFF) begin errors++;
            $display("FAIL bar7 got %h%h%h want FFF", red_a, green_a, blue_a); end
        tm_a = 1'b0;
        color_mode = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_frame_timing();
        test_hsync();
        test_vsync();
        test_colour();
`ifdef VGA_TESTPATTERN_EN
        test_pattern();
`endif
        test_park_and_reset();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
